// File: rtl/can_crc_seq.sv
// can_crc_seq: receive-side CAN CRC-15 sequencer.
// Follows a de-stuffed bit stream from SOF through the data field and feeds
// those bits into a CRC-15 LFSR. It then collects the 15 received CRC bits and
// reports crc_ok / crc_err once per frame.
// Optional build macro: CAN_CRC_EXT_ID_EN adds support for extended (29-bit
// ID) frames. Without it, IDE=1 is reported on fmt_err.
//
// Input strobe semantics: bit_valid is a one-cycle qualifier with no
// back-pressure. Every cycle where bit_valid=1 delivers exactly one new
// de-stuffed bit on rx_bit, and strobes may arrive on consecutive cycles.
// abort takes priority over a bit_valid in the same cycle.
module can_crc_seq #(
    parameter int ID_STD_BITS    = 11,
    parameter int MAX_DATA_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_valid,
    input  logic        rx_bit,
    input  logic        abort,
    output logic        busy,
    output logic [14:0] crc_value,
    output logic [3:0]  dlc,
    output logic        crc_done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        fmt_err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_CTRL   = 3'd2,
        S_DATA   = 3'd3,
        S_CRC_RX = 3'd4,
        S_DONE   = 3'd5
`ifdef CAN_CRC_EXT_ID_EN
        ,
        S_EXT    = 3'd6
`endif
    } state_t;

    localparam logic [14:0] CRC_POLY  = 15'h4599;
    // ARB covers ID bits 0..ID_STD_BITS-1 followed by the RTR slot.
    localparam logic [6:0]  ARB_LAST  = 7'(ID_STD_BITS);
    // CTRL covers IDE (0), r0 (1), and DLC[3:0] (2..5).
    localparam logic [6:0]  CTRL_DLC0 = 7'd2;
    localparam logic [6:0]  CTRL_LAST = 7'd5;
    localparam logic [6:0]  CRC_LAST  = 7'd14;
    localparam logic [3:0]  MAX_DLC   = 4'(MAX_DATA_BYTES);
`ifdef CAN_CRC_EXT_ID_EN
    // Extended tail after IDE: ID bits 0..17, RTR 18, r1 19, r0 20, DLC 21..24.
    localparam logic [6:0]  EXT_RTR   = 7'd18;
    localparam logic [6:0]  EXT_DLC0  = 7'd21;
    localparam logic [6:0]  EXT_LAST  = 7'd24;
`endif

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [14:0] crc_q, crc_d;
    logic [13:0] rx_crc_q, rx_crc_d;
    logic [3:0]  dlc_q, dlc_d;
    logic        rtr_q, rtr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic        fmt_q, fmt_d;

    // Values derived from the incoming bit, shared by several states.
    logic [14:0] crc_next;
    logic [3:0]  dlc_full;
    logic [3:0]  dlc_clamped;
    logic [6:0]  nbits;
    logic [14:0] rx_crc_full;
    state_t      payload_state;
    logic [6:0]  payload_cnt;

    // One CRC-15 step: shift left and fold in the polynomial when the
    // incoming bit differs from the outgoing MSB.
    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        crc_step = {c[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
    endfunction

    // Helpers: next CRC, assembled DLC/CRC words, and where the frame goes after DLC.
    always_comb begin
        crc_next    = crc_step(crc_q, rx_bit);
        dlc_full    = {dlc_q[2:0], rx_bit};
        dlc_clamped = (dlc_full > MAX_DLC) ? MAX_DLC : dlc_full;
        nbits       = rtr_q ? 7'd0 : {dlc_clamped, 3'b000};
        rx_crc_full = {rx_crc_q, rx_bit};
        if (nbits == 7'd0) begin
            payload_state = S_CRC_RX;
            payload_cnt   = 7'd0;
        end else begin
            payload_state = S_DATA;
            payload_cnt   = nbits;
        end
    end

    // Next-state logic: field tracking, CRC coverage, and result pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        rx_crc_d = rx_crc_q;
        dlc_d    = dlc_q;
        rtr_d    = rtr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        fmt_d    = 1'b0;

        if (abort) begin
            state_d  = S_IDLE;
            cnt_d    = 7'd0;
            crc_d    = 15'h0000;
            rx_crc_d = 14'h0000;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A dominant strobe is SOF. It is covered, starting from a cleared LFSR.
                    if (bit_valid && !rx_bit) begin
                        state_d  = S_ARB;
                        cnt_d    = 7'd0;
                        crc_d    = crc_step(15'h0000, rx_bit);
                        rx_crc_d = 14'h0000;
                        rtr_d    = 1'b0;
                        busy_d   = 1'b1;
                    end
                end
                S_ARB: begin
                    if (bit_valid) begin
                        crc_d = crc_next;
                        if (cnt_q == ARB_LAST) begin
                            rtr_d   = rx_bit;
                            cnt_d   = 7'd0;
                            state_d = S_CTRL;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                end
                S_CTRL: begin
                    if (bit_valid) begin
                        crc_d = crc_next;
                        cnt_d = cnt_q + 7'd1;
                        if (cnt_q >= CTRL_DLC0) begin
                            dlc_d = dlc_full;
                        end
                        if (cnt_q == 7'd0 && rx_bit) begin
`ifdef CAN_CRC_EXT_ID_EN
                            // The standard RTR slot held SRR. The real RTR comes later.
                            state_d = S_EXT;
                            cnt_d   = 7'd0;
`else
                            fmt_d   = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = 7'd0;
                            crc_d   = 15'h0000;
                            busy_d  = 1'b0;
`endif
                        end else if (cnt_q == CTRL_LAST) begin
                            state_d = payload_state;
                            cnt_d   = payload_cnt;
                        end
                    end
                end
`ifdef CAN_CRC_EXT_ID_EN
                S_EXT: begin
                    if (bit_valid) begin
                        crc_d = crc_next;
                        cnt_d = cnt_q + 7'd1;
                        if (cnt_q == EXT_RTR) begin
                            rtr_d = rx_bit;
                        end
                        if (cnt_q >= EXT_DLC0) begin
                            dlc_d = dlc_full;
                        end
                        if (cnt_q == EXT_LAST) begin
                            state_d = payload_state;
                            cnt_d   = payload_cnt;
                        end
                    end
                end
`endif
                S_DATA: begin
                    // The counter was loaded with nbits and counts down to the last data bit.
                    if (bit_valid) begin
                        crc_d = crc_next;
                        if (cnt_q == 7'd1) begin
                            state_d = S_CRC_RX;
                            cnt_d   = 7'd0;
                        end else begin
                            cnt_d = cnt_q - 7'd1;
                        end
                    end
                end
                S_CRC_RX: begin
                    // Received CRC bits are only collected. They never enter the LFSR.
                    if (bit_valid) begin
                        rx_crc_d = rx_crc_full[13:0];
                        if (cnt_q == CRC_LAST) begin
                            state_d = S_DONE;
                            cnt_d   = 7'd0;
                            done_d  = 1'b1;
                            ok_d    = (rx_crc_full == crc_q);
                            err_d   = (rx_crc_full != crc_q);
                            busy_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 7'd0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 7'd0;
            crc_q    <= 15'h0000;
            rx_crc_q <= 14'h0000;
            dlc_q    <= 4'd0;
            rtr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            fmt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            rx_crc_q <= rx_crc_d;
            dlc_q    <= dlc_d;
            rtr_q    <= rtr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            fmt_q    <= fmt_d;
        end
    end

    assign busy      = busy_q;
    assign crc_value = crc_q;
    assign dlc       = dlc_q;
    assign crc_done  = done_q;
    assign crc_ok    = ok_q;
    assign crc_err   = err_q;
    assign fmt_err   = fmt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_can_crc_seq.sv
// tb_can_crc_seq: directed bench for can_crc_seq.
// It applies a table of standard frames and then hand-written sequences for
// abort, format error / extended frames, and reset in the middle of a frame.
module tb_can_crc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_valid;
    logic        rx_bit;
    logic        abort;
    logic        busy;
    logic [14:0] crc_value;
    logic [3:0]  dlc;
    logic        crc_done;
    logic        crc_ok;
    logic        crc_err;
    logic        fmt_err;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic frame_q[$];

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic        hand;      // 1: exp_crc is a hand-computed constant
        logic [14:0] exp_crc;
        logic        corrupt;   // 1: flip bit 0 of the transmitted CRC
        int          gap;       // idle cycles between strobes
    } vec_t;

    vec_t vecs[7];

    can_crc_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .rx_bit    (rx_bit),
        .abort     (abort),
        .busy      (busy),
        .crc_value (crc_value),
        .dlc       (dlc),
        .crc_done  (crc_done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .fmt_err   (fmt_err),
        .dbg_state (dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC-15 over the first n queued bits.
    function automatic logic [14:0] model_crc(input int n);
        logic [14:0] c;
        logic        fb;
        c = 15'h0000;
        for (int i = 0; i < n; i++) begin
            fb = frame_q[i] ^ c[14];
            c  = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
        end
        return c;
    endfunction

    task automatic build_std(input logic [10:0] id, input logic rtr, input logic [3:0] d,
                             input logic [63:0] data);
        int nb;
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 10; i >= 0; i--) frame_q.push_back(id[i]);
        frame_q.push_back(rtr);
        frame_q.push_back(1'b0);
        frame_q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) frame_q.push_back(d[i]);
        nb = rtr ? 0 : 8 * ((d > 4'd8) ? 8 : int'(d));
        for (int i = 0; i < nb; i++) frame_q.push_back(data[63-i]);
    endtask

    task automatic append_crc(input logic [14:0] c);
        for (int i = 14; i >= 0; i--) frame_q.push_back(c[i]);
    endtask

    // Strobe queued bits [from..to]. Returns at posedge+1 after the last strobe with bit_valid low.
    task automatic send_bits(input int from, input int to, input int gap);
        for (int i = from; i <= to; i++) begin
            bit_valid = 1'b1;
            rx_bit    = frame_q[i];
            tick();
            bit_valid = 1'b0;
            rx_bit    = 1'b1;
            if (i != to) repeat (gap) tick();
        end
    endtask

    task automatic send_recessive(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            rx_bit    = 1'b1;
            tick();
            bit_valid = 1'b0;
        end
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [14:0] exp;
        logic [14:0] rxc;
        build_std(v.id, v.rtr, v.dlc, v.data);
        exp = v.hand ? v.exp_crc : model_crc(frame_q.size());
        rxc = v.corrupt ? (exp ^ 15'h0001) : exp;
        append_crc(rxc);
        send_recessive(2, tag);
        send_bits(0, 0, 0);
        check({tag, " busy after SOF"}, 32'(busy), 32'd1);
        send_bits(1, frame_q.size() - 2, v.gap);
        check({tag, " no early done"}, 32'(crc_done), 32'd0);
        send_bits(frame_q.size() - 1, frame_q.size() - 1, 0);
        check({tag, " crc_done"}, 32'(crc_done), 32'd1);
        check({tag, " crc_ok"}, 32'(crc_ok), 32'(!v.corrupt));
        check({tag, " crc_err"}, 32'(crc_err), 32'(v.corrupt));
        check({tag, " crc_value"}, 32'(crc_value), 32'(exp));
        check({tag, " dlc"}, 32'(dlc), 32'(v.dlc));
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        tick();
        check({tag, " done one cycle"}, 32'(crc_done), 32'd0);
        check({tag, " crc_value holds"}, 32'(crc_value), 32'(exp));
    endtask

    vec_t zero_v;
    vec_t one_v;

    initial begin
        int pulses;

        // id, rtr, dlc, data, hand, exp_crc, corrupt, gap
        vecs[0] = '{11'h000, 1'b0, 4'd0, 64'h0, 1'b1, 15'h0000, 1'b0, 0};
        vecs[1] = '{11'h000, 1'b0, 4'd1, 64'h0, 1'b1, 15'h4426, 1'b0, 1};
        vecs[2] = '{11'h000, 1'b0, 4'd1, 64'h0, 1'b1, 15'h4426, 1'b1, 0};
        vecs[3] = '{11'h000, 1'b1, 4'd8, 64'h0, 1'b1, 15'h07C2, 1'b0, 0};
        vecs[4] = '{11'h5A5, 1'b0, 4'd15, 64'h0123456789ABCDEF, 1'b0, 15'h0, 1'b0, 0};
        vecs[5] = '{11'h7FF, 1'b0, 4'd2, 64'hA55A000000000000, 1'b0, 15'h0, 1'b1, 2};
        vecs[6] = '{11'h123, 1'b0, 4'd9, 64'hFFFFFFFFFFFFFFFF, 1'b0, 15'h0, 1'b0, 1};
        zero_v  = vecs[0];
        one_v   = vecs[1];

        // Reset block.
        rst       = 1'b1;
        bit_valid = 1'b0;
        rx_bit    = 1'b1;
        abort     = 1'b0;
        repeat (3) tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset crc_value", 32'(crc_value), 32'd0);
        check("reset dlc", 32'(dlc), 32'd0);
        check("reset flags", {28'd0, crc_done, crc_ok, crc_err, fmt_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort during data bit 3. The LFSR value after the DLC field is checked on the way.
        build_std(11'h000, 1'b0, 4'd1, 64'h0);
        send_bits(0, 18, 0);
        check("abort seq crc after dlc", 32'(crc_value), 32'h4599);
        send_bits(19, 21, 0);
        abort     = 1'b1;
        bit_valid = 1'b1;
        rx_bit    = 1'b0;
        tick();
        abort     = 1'b0;
        bit_valid = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort crc cleared", 32'(crc_value), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (crc_done) pulses++;
            tick();
        end
        check("abort no crc_done", 32'(pulses), 32'd0);
        run_vec(zero_v, "after abort");

        // IDE=1 frame.
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 0; i < 11; i++) frame_q.push_back(1'b0);
        frame_q.push_back(1'b1);        // SRR in the RTR slot
        frame_q.push_back(1'b1);        // IDE
`ifdef CAN_CRC_EXT_ID_EN
        begin
            logic [17:0] eid;
            logic [14:0] ec;
            eid = 18'h2AAAA;
            for (int i = 17; i >= 0; i--) frame_q.push_back(eid[i]);
            frame_q.push_back(1'b0);    // RTR
            frame_q.push_back(1'b0);    // r1
            frame_q.push_back(1'b0);    // r0
            frame_q.push_back(1'b0);    // DLC = 2
            frame_q.push_back(1'b0);
            frame_q.push_back(1'b1);
            frame_q.push_back(1'b0);
            for (int i = 0; i < 16; i++) frame_q.push_back(i[0]);
            ec = model_crc(frame_q.size());
            append_crc(ec);
            pulses = 0;
            for (int i = 0; i < 39 + 16 + 14; i++) begin
                send_bits(i, i, 0);
                if (crc_done || fmt_err) pulses++;
            end
            check("ext no early pulse", 32'(pulses), 32'd0);
            send_bits(39 + 16 + 14, 39 + 16 + 14, 0);
            check("ext crc_done", 32'(crc_done), 32'd1);
            check("ext crc_ok", 32'(crc_ok), 32'd1);
            check("ext dlc", 32'(dlc), 32'd2);
            check("ext crc_value", 32'(crc_value), 32'(ec));
        end
`else
        send_bits(0, frame_q.size() - 1, 0);
        check("ide fmt_err", 32'(fmt_err), 32'd1);
        check("ide busy", 32'(busy), 32'd0);
        check("ide no crc_done", 32'(crc_done), 32'd0);
        tick();
        check("ide fmt_err one cycle", 32'(fmt_err), 32'd0);
`endif
        tick();
        run_vec(zero_v, "after ide");

        // Reset in the middle of CRC_RX, with crc_value and dlc nonzero.
        build_std(11'h000, 1'b0, 4'd1, 64'h0);
        append_crc(15'h4426);
        send_bits(0, 31, 0);
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst crc_value", 32'(crc_value), 32'd0);
        check("midrst dlc", 32'(dlc), 32'd0);
        check("midrst flags", {28'd0, crc_done, crc_ok, crc_err, fmt_err}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_recessive(5, "post reset");
        check("post reset crc_done", 32'(crc_done), 32'd0);
        run_vec(one_v, "after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its end, got running, expected finished");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
